tmds_channel_sched: RTL and testbench

TMDS_CHANNEL_SCHED -- requirements
Module: tmds_channel_sched

---
 rtl/tmds_pkg.sv | 12 +
 rtl/tmds_shift10.sv | 19 +
 rtl/tmds_channel_sched.sv | 65 ++++++
 tb/tb_tmds_channel_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared states, symbol length and control tokens for the TMDS channel scheduler
package tmds_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;
    localparam int SYM_LEN = 10;
    localparam logic [SYM_LEN-1:0] TOK_00 = 10'b1101010100;
    localparam logic [SYM_LEN-1:0] TOK_01 = 10'b0010101011;
    localparam logic [SYM_LEN-1:0] TOK_10 = 10'b0101010100;
    localparam logic [SYM_LEN-1:0] TOK_11 = 10'b1010101011;
    function automatic logic [SYM_LEN-1:0] ctrl_token(input logic [1:0] c);
        return c == 2'b00 ? TOK_00 : c == 2'b01 ? TOK_01 : c == 2'b10 ? TOK_10 : TOK_11;
    endfunction
endpackage

// File: rtl/tmds_shift10.sv
// tmds_shift10: 10-bit symbol register, parallel load or LSB-first serial shift with zero fill
module tmds_shift10
    import tmds_pkg::*;
(
    input  logic               clk,
    input  logic               s_rst,
    input  logic               load,
    input  logic [SYM_LEN-1:0] d,
    output logic               bit0
);
    logic [SYM_LEN-1:0] sr_q, sr_d;
    // reload at a symbol boundary, otherwise move the next bit into position 0
    always_comb sr_d = load ? d : {1'b0, sr_q[SYM_LEN-1:1]};
    // reset parks the line on the 00 control token
    always_ff @(posedge clk)
        if (s_rst) sr_q <= TOK_00;
        else sr_q <= sr_d;
    assign bit0 = sr_q[0];
endmodule

// File: rtl/tmds_channel_sched.sv
// tmds_channel_sched: per-symbol scheduler for one TMDS channel (pixel hold, encoder handshake, serializer)
module tmds_channel_sched
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       s_rst,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] enc_pix,
    input  logic [9:0] enc_q,
    output logic       enc_load,
    output logic       enc_s_rst,
    output logic       tmds_bit,
    output logic       underrun
);
    logic [3:0] sym_cnt_q, sym_cnt_d;
    state_t     state_q, state_d;
    logic [7:0] hold_reg_q, hold_reg_d;
    logic       hold_full_q, hold_full_d;
    logic       underrun_q, underrun_d;
    logic       boundary, take;
    logic [SYM_LEN-1:0] shift_d;
    assign boundary  = sym_cnt_q == 4'(SYM_LEN - 1);
    assign pix_ready = !s_rst && de && !hold_full_q && !boundary;
    assign take      = pix_valid && pix_ready;
    assign enc_load  = !s_rst && boundary && de;
    assign enc_s_rst = s_rst || state_q != ACTIVE;
    assign enc_pix   = hold_reg_q;
    assign underrun  = underrun_q;
    assign shift_d   = de ? enc_q : ctrl_token(ctrl);
    // next state: mode and hold slot only change at the boundary; a pixel can only land mid-symbol
    always_comb begin
        sym_cnt_d   = boundary ? 4'd0 : sym_cnt_q + 4'd1;
        state_d     = boundary ? (de ? ACTIVE : BLANK) : state_q;
        hold_reg_d  = take ? pix_data : hold_reg_q;
        hold_full_d = take ? 1'b1 : (boundary ? 1'b0 : hold_full_q);
        underrun_d  = underrun_q || (boundary && de && !hold_full_q);
    end
    // state registers; reset aborts the current symbol and restarts the count
    always_ff @(posedge clk) begin
        if (s_rst) begin
            sym_cnt_q   <= 4'd0;
            state_q     <= IDLE;
            hold_reg_q  <= 8'd0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            state_q     <= state_d;
            hold_reg_q  <= hold_reg_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
        end
    end
    tmds_shift10 u_shift (
        .clk  (clk),
        .s_rst(s_rst),
        .load (boundary),
        .d    (shift_d),
        .bit0 (tmds_bit)
    );
endmodule

// File: tb/tb_tmds_channel_sched.sv
// tb_tmds_channel_sched: scoreboard bench for the TMDS channel scheduler
module tb_tmds_channel_sched;
    logic       clk = 1'b0;
    logic       s_rst, de, pix_valid;
    logic [1:0] ctrl;
    logic [7:0] pix_data, enc_pix;
    logic [9:0] enc_q;
    logic       pix_ready, enc_load, enc_s_rst, tmds_bit, underrun;

    int   n_cmp = 0, n_bad = 0;
    int   m_ph = 0, m_state = 0;
    logic m_full = 1'b0, m_under = 1'b0;
    logic [7:0] m_hold = 8'd0;
    logic sb[$];
    logic e_bit, e_bit_v, e_ready, e_load, e_srst;
    logic [9:0] tok00 = 10'b1101010100;
    logic [9:0] tok01 = 10'b0010101011;
    logic [9:0] tok10 = 10'b0101010100;
    logic [9:0] tok11 = 10'b1010101011;

    always #5 clk = ~clk;

    function automatic logic [9:0] enc_model(input logic [7:0] p);
        return {^p, ~p[0], p ^ 8'h5A};
    endfunction

    assign enc_q = enc_model(enc_pix);

    tmds_channel_sched dut (
        .clk(clk), .s_rst(s_rst), .de(de), .ctrl(ctrl),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .enc_pix(enc_pix), .enc_q(enc_q), .enc_load(enc_load),
        .enc_s_rst(enc_s_rst), .tmds_bit(tmds_bit), .underrun(underrun)
    );

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) sb.push_back(s[i]);
    endtask

    // settle inputs, derive expected outputs for this cycle, pop the expected serial bit
    task automatic cyc();
        #1;
        e_ready = !s_rst && de && !m_full && m_ph != 9;
        e_load  = !s_rst && de && m_ph == 9;
        e_srst  = s_rst || m_state != 2;
        e_bit_v = sb.size() > 0;
        e_bit   = e_bit_v ? sb.pop_front() : 1'b0;
    endtask

    // advance the reference model across the coming edge, then step to the next drive slot
    task automatic fin();
        if (s_rst) begin
            m_ph = 0; m_state = 0; m_full = 0; m_hold = 0; m_under = 0;
            sb.delete();
            push_sym(tok00);
        end else if (m_ph == 9) begin
            push_sym(de ? enc_model(m_hold) : (ctrl == 2'b00 ? tok00 : ctrl == 2'b01 ? tok01 : ctrl == 2'b10 ? tok10 : tok11));
            if (de && !m_full) m_under = 1;
            m_state = de ? 2 : 1;
            m_full = 0;
            m_ph = 0;
        end else begin
            if (pix_valid && e_ready) begin m_hold = pix_data; m_full = 1; end
            m_ph++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst = 1; de = 0; ctrl = 2'b00; pix_valid = 0; pix_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i > 0) begin
                n_cmp++; if (tmds_bit !== 1'b0) begin n_bad++; $display("FAIL rst_bit: got %b want 0", tmds_bit); end
                n_cmp++; if (enc_s_rst !== 1'b1) begin n_bad++; $display("FAIL rst_enc_s_rst: got %b want 1", enc_s_rst); end
                n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pix_ready: got %b want 0", pix_ready); end
                n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
                n_cmp++; if (enc_load !== 1'b0) begin n_bad++; $display("FAIL rst_enc_load: got %b want 0", enc_load); end
            end
            fin();
        end
        s_rst = 0; de = 1; pix_valid = 1; pix_data = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++; if (enc_load !== (i == 9)) begin n_bad++; $display("FAIL first_boundary cyc %0d: enc_load got %b want %b", i, enc_load, i == 9); end
            if (e_bit_v) begin n_cmp++; if (tmds_bit !== e_bit) begin n_bad++; $display("FAIL post_rst_bit cyc %0d: got %b want %b", i, tmds_bit, e_bit); end end
            fin();
        end
    endtask

    task automatic test_blanking();
        de = 0; ctrl = 2'b01; pix_valid = 1; pix_data = 8'hFF;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (e_bit_v) begin n_cmp++; if (tmds_bit !== e_bit) begin n_bad++; $display("FAIL blank_sb_bit cyc %0d: got %b want %b", i, tmds_bit, e_bit); end end
            if (i >= 10) begin n_cmp++; if (tmds_bit !== tok01[i % 10]) begin n_bad++; $display("FAIL blank_pattern cyc %0d: got %b want %b", i, tmds_bit, tok01[i % 10]); end end
            n_cmp++; if (enc_load !== 1'b0) begin n_bad++; $display("FAIL blank_enc_load cyc %0d: got %b want 0", i, enc_load); end
            n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL blank_pix_ready cyc %0d: got %b want 0", i, pix_ready); end
            n_cmp++; if (enc_s_rst !== e_srst) begin n_bad++; $display("FAIL blank_enc_s_rst cyc %0d: got %b want %b", i, enc_s_rst, e_srst); end
            fin();
        end
    endtask

    task automatic test_active();
        int xfers = 0;
        de = 1; pix_valid = 1;
        for (int i = 0; i < 40; i++) begin
            pix_data = (i < 10) ? 8'hA5 : 8'($urandom);
            cyc();
            if (pix_ready && pix_valid) xfers++;
            n_cmp++; if (pix_ready !== e_ready) begin n_bad++; $display("FAIL act_pix_ready cyc %0d: got %b want %b", i, pix_ready, e_ready); end
            n_cmp++; if (enc_load !== e_load) begin n_bad++; $display("FAIL act_enc_load cyc %0d: got %b want %b", i, enc_load, e_load); end
            n_cmp++; if (enc_s_rst !== e_srst) begin n_bad++; $display("FAIL act_enc_s_rst cyc %0d: got %b want %b", i, enc_s_rst, e_srst); end
            n_cmp++; if (enc_pix !== m_hold && i > 0) begin n_bad++; $display("FAIL act_enc_pix cyc %0d: got %h want %h", i, enc_pix, m_hold); end
            n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL act_underrun cyc %0d: got %b want 0", i, underrun); end
            if (e_bit_v) begin n_cmp++; if (tmds_bit !== e_bit) begin n_bad++; $display("FAIL act_bit cyc %0d: got %b want %b", i, tmds_bit, e_bit); end end
            fin();
        end
        n_cmp++; if (xfers !== 4) begin n_bad++; $display("FAIL act_xfers_per_period: got %0d want 4", xfers); end
    endtask

    task automatic test_underrun();
        de = 1; pix_valid = 0; pix_data = 8'h77;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) pix_valid = 1;
            cyc();
            n_cmp++; if (enc_load !== (i % 10 == 9)) begin n_bad++; $display("FAIL und_enc_load cyc %0d: got %b want %b", i, enc_load, i % 10 == 9); end
            n_cmp++; if (underrun !== (i >= 10)) begin n_bad++; $display("FAIL und_flag cyc %0d: got %b want %b", i, underrun, i >= 10); end
            if (e_bit_v) begin n_cmp++; if (tmds_bit !== e_bit) begin n_bad++; $display("FAIL und_bit cyc %0d: got %b want %b", i, tmds_bit, e_bit); end end
            fin();
        end
    endtask

    task automatic test_mode_change();
        de = 1; pix_valid = 1; pix_data = 8'hC3; ctrl = 2'b10;
        for (int j = 0; j < 30; j++) begin
            if (j == 5) de = 0;
            cyc();
            n_cmp++; if (enc_s_rst !== (j >= 10)) begin n_bad++; $display("FAIL mode_enc_s_rst cyc %0d: got %b want %b", j, enc_s_rst, j >= 10); end
            if (j >= 5) begin n_cmp++; if (enc_load !== 1'b0) begin n_bad++; $display("FAIL mode_enc_load cyc %0d: got %b want 0", j, enc_load); end end
            if (j >= 10 && j < 20) begin n_cmp++; if (tmds_bit !== tok10[j - 10]) begin n_bad++; $display("FAIL mode_token cyc %0d: got %b want %b", j, tmds_bit, tok10[j - 10]); end end
            if (e_bit_v) begin n_cmp++; if (tmds_bit !== e_bit) begin n_bad++; $display("FAIL mode_bit cyc %0d: got %b want %b", j, tmds_bit, e_bit); end end
            fin();
        end
    endtask

    task automatic test_reset_mid();
        de = 1; pix_valid = 1; pix_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin cyc(); fin(); end
        s_rst = 1;
        cyc();
        n_cmp++; if (enc_load !== 1'b0) begin n_bad++; $display("FAIL mid_rst_enc_load: got %b want 0", enc_load); end
        n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pix_ready: got %b want 0", pix_ready); end
        fin();
        s_rst = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            n_cmp++; if (enc_s_rst !== (i < 10)) begin n_bad++; $display("FAIL mid_enc_s_rst cyc %0d: got %b want %b", i, enc_s_rst, i < 10); end
            n_cmp++; if (enc_load !== (i == 9)) begin n_bad++; $display("FAIL mid_enc_load cyc %0d: got %b want %b", i, enc_load, i == 9); end
            n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL mid_underrun cyc %0d: got %b want 0", i, underrun); end
            if (i < 10) begin n_cmp++; if (tmds_bit !== tok00[i]) begin n_bad++; $display("FAIL mid_tok00 cyc %0d: got %b want %b", i, tmds_bit, tok00[i]); end end
            if (e_bit_v) begin n_cmp++; if (tmds_bit !== e_bit) begin n_bad++; $display("FAIL mid_bit cyc %0d: got %b want %b", i, tmds_bit, e_bit); end end
            fin();
        end
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_active();
        test_underrun();
        test_mode_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
